// File: rtl/nxn_reg_mux.sv
// Registered N-to-1 word multiplexer with fixed-select or round-robin grant
// and valid/ready handshaking on every input and on the single output entry.
module nxn_reg_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          S,
  output logic [WIDTH-1:0]          RES,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SEL_W-1:0]          res_ch
);

  localparam int NPAD = 1 << SEL_W;

  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [SEL_W-1:0] res_ch_q, res_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [NPAD-1:0]  valid_pad;
  logic [WIDTH-1:0] ch_data [CHANNELS];
  int               idx;

  assign load_en   = !res_valid_q || res_ready;
  // Padding lets an out-of-range S index safely before the range check masks it.
  assign valid_pad = NPAD'(in_valid);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign ch_data[g]  = in_data[g*WIDTH +: WIDTH];
    assign in_ready[g] = reset_n && gnt_vld && (gnt_idx == SEL_W'(g));
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (load_en) begin
      if (!mode) begin
        if ((int'(S) < CHANNELS) && valid_pad[S]) begin
          gnt_vld = 1'b1;
          gnt_idx = S;
        end
      end else begin
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
          idx = (int'(rr_ptr_q) + int'(k)) % CHANNELS;
          if (!gnt_vld && valid_pad[SEL_W'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    res_d       = res_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      res_valid_d = gnt_vld;
      if (gnt_vld) begin
        res_d    = ch_data[gnt_idx];
        res_ch_d = gnt_idx;
        if (mode) rr_ptr_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(CHANNELS - 1);
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign RES       = res_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;

endmodule

// File: doc/nxn_reg_mux.md
Name: nxn_reg_mux

Overview:
- Parametrised, registered successor to the team's 2x1 mux.
- Selects one of CHANNELS input words of WIDTH bits and presents it on a single registered output.
- Two selection modes: fixed select (S input) or round-robin arbitration.
- Valid/ready handshake on every input and on the output.
- Sits between multiple producer units (e.g. ALU result sources) and a single consumer bus.

Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels, >= 2
- SEL_W, 2, select/index width, = clog2(CHANNELS)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept (combinational)
- mode  input  1  0 = fixed select via S, 1 = round-robin
- S  input  SEL_W  channel index in fixed mode
- RES  output  WIDTH  registered selected data
- res_valid  output  1  RES holds a word
- res_ready  input  1  consumer accepts RES
- res_ch  output  SEL_W  index of the channel that produced RES

Behaviour:
- Reset: sampled on rising clk when reset_n = 0.
  - RES = 0, res_valid = 0, res_ch = 0, rr_ptr = CHANNELS-1.
  - in_ready = all 0 while reset_n = 0.
  - Reset mid-transfer discards the held word.
- Output register is a single entry.
  - load_en = !res_valid || res_ready.
- Grant (combinational, only when load_en = 1):
  - Fixed mode: grant channel S if S < CHANNELS and in_valid[S] = 1; otherwise no grant. S >= CHANNELS never grants.
  - RR mode: grant the first i with in_valid[i] = 1, searching rr_ptr+1, rr_ptr+2, … circularly (wraps CHANNELS-1 -> 0). No grant if no input is valid.
- in_ready[i] = 1 only for the granted channel. At most one bit is set.
- Transfer on an input occurs when in_valid[i] && in_ready[i] at the clock edge.
- On a transfer, next edge:
  - RES <= in_data slice of the granted channel.
  - res_ch <= granted channel.
  - res_valid <= 1.
  - RR mode only: rr_ptr <= granted channel.
- No grant and res_ready = 1: res_valid <= 0. RES and res_ch hold their last values.
- res_valid = 1 and res_ready = 0: RES, res_ch and res_valid hold stable. All in_ready = 0.
- Simultaneous drain and load (res_valid && res_ready and a grant): new word is loaded the same edge. Sustained throughput is 1 word/cycle.
- Latency: 1 cycle from input transfer to res_valid.
- Mode and S are sampled combinationally each cycle. A change affects only the next grant.
- rr_ptr is unchanged in fixed mode and is not reset by a mode switch.
- Input data is not stored beyond the output register. A non-granted input must keep in_valid and in_data stable until accepted.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with all in_valid = 1 -> in_ready = 0000, res_valid = 0, RES = 00, res_ch = 0.
- Fixed mode:
  - Setup: mode = 0, S = 2, in_data = {44,33,22,11}h, all valid, res_ready = 1.
  - Required: cycle after, RES = 33h, res_ch = 2, in_ready = 0100.
  - Then set S = 3 -> next RES = 44h.
- Round-robin fairness:
  - Setup: mode = 1, all valid, res_ready = 1 from reset.
  - Required: res_ch sequence 0,1,2,3,0 on consecutive cycles, with RES = 11,22,33,44,11h.
- Backpressure:
  - Setup: RR mode, res_ready = 0 after the first load.
  - Required: RES = 11h and res_ch = 0 held for 3 cycles with in_ready = 0000.
  - Release res_ready -> next RES = 22h. No channel is skipped.
- Sparse/wrap:
  - Setup: RR mode, only in_valid[3] and in_valid[0] set, rr_ptr = 0.
  - Required: grants 3, then 0, then 3.
  - Drop all valids -> res_valid falls to 0 one cycle after a drain.
- Out-of-range/reset mid-op:
  - CHANNELS = 3 instance, mode = 0, S = 3 -> no grant, res_valid stays 0.
  - Assert reset_n = 0 while res_valid = 1 -> next edge res_valid = 0, RES = 0.
